// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock, start/busy/done handshake.
// Optional unsigned-operand mode is enabled by defining BOOTH_UNSIGNED_EN (adds the sgn port).
module booth_r4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  // Handshake: start is accepted only in IDLE; busy is high for every RUN cycle;
  // done is a single-cycle pulse with product valid, after which the unit is IDLE again.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef BOOTH_UNSIGNED_EN
  localparam int NMAX = WIDTH/2 + 1;
`else
  localparam int NMAX = WIDTH/2;
`endif
  localparam int MW    = 2*NMAX + 1;
  localparam int ACC_W = 2*WIDTH + 4;
  localparam int CW    = $clog2(NMAX + 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    last_q, last_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [MW-1:0]    mult_q, mult_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic             sgn_w;
  logic [ACC_W-1:0] a_ext;
  logic [MW-1:0]    b_win;
  logic [2:0]       win;
  logic             one, two, neg;
  logic [ACC_W-1:0] mag, pp, acc_sum;

`ifdef BOOTH_UNSIGNED_EN
  assign sgn_w = sgn;
  assign b_win = {{2{sgn_w & b[WIDTH-1]}}, b, 1'b0};
`else
  assign sgn_w = 1'b1;
  assign b_win = {b, 1'b0};
`endif
  assign a_ext = {{(ACC_W-WIDTH){sgn_w & a[WIDTH-1]}}, a};

  // The multiplicand is pre-shifted by two each cycle, so it already carries weight 4^i.
  always_comb begin
    win     = mult_q[2:0];
    one     = win[1] ^ win[0];
    two     = (~win[2] & win[1] & win[0]) | (win[2] & ~win[1] & ~win[0]);
    neg     = win[2] & ~(win[1] & win[0]);
    mag     = two ? (mcand_q << 1) : (one ? mcand_q : '0);
    pp      = neg ? ((~mag) + {{(ACC_W-1){1'b0}}, 1'b1}) : mag;
    acc_sum = acc_q + pp;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a_ext;
          mult_d  = b_win;
          acc_d   = '0;
          cnt_d   = '0;
          last_d  = sgn_w ? CW'(WIDTH/2 - 1) : CW'(NMAX - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 2;
        mult_d  = mult_q >> 2;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == last_q) begin
          product_d = acc_sum[2*WIDTH-1:0];
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule
